// File: rtl/hex_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed hex display scanner.
package hex_scan_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    localparam int unsigned DEF_DIV       = 50000;
    localparam int unsigned DEF_BLANK_CYC = 16;
    localparam int unsigned MAX_DIG       = 32;

    // Active-low one-hot digit enable; callers truncate to their digit count.
    function automatic logic [MAX_DIG-1:0] digit_en_n(input int unsigned idx);
        return ~(MAX_DIG'(1) << idx);
    endfunction

endpackage

// File: rtl/hex_scan_ctrl_if.sv
// Load handshake and display-drive signals of the hex scan controller.
interface hex_scan_ctrl_if #(
    parameter int unsigned NDIG = 4
) ();
    logic                load;
    logic [4*NDIG-1:0]   value_in;
    logic                load_ack;
    logic [3:0]          nibble;
    logic [NDIG-1:0]     dig_en_n;
    logic                frame_done;

    modport master (
        output load, value_in,
        input  load_ack, nibble, dig_en_n, frame_done
    );

    modport slave (
        input  load, value_in,
        output load_ack, nibble, dig_en_n, frame_done
    );
endinterface

// File: rtl/hex_scan_ctrl_tick_gen.sv
// Digit-slot prescaler: counts clk cycles within a slot and splits it into
// a blanking phase followed by a show phase.
module scan_tick_gen
    import hex_scan_pkg::*;
#(
    parameter int unsigned DIV       = DEF_DIV,
    parameter int unsigned BLANK_CYC = DEF_BLANK_CYC
) (
    input  logic clk,
    input  logic reset,
    output logic slot_start,
    output logic show
);
    localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] BLK  = CW'(BLANK_CYC);

    logic [CW-1:0] slot_cnt_q;
    logic [CW-1:0] slot_cnt_d;

    always_comb begin
        slot_cnt_d = (slot_cnt_q == LAST) ? '0 : slot_cnt_q + 1'b1;
        if (reset) begin
            slot_cnt_d = '0;
        end
    end

    // Both flags qualify the cycle after the coming edge, so registered
    // outputs in the top line up exactly with the slot counter.
    assign slot_start = (slot_cnt_d == '0);
    assign show       = (slot_cnt_d >= BLK);

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt_q <= '0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
        end
    end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed hex scan controller with frame-aligned value commits.
// Optional leading-zero blanking: define HEX_SCAN_LZB_EN.
module hex_scan_ctrl
    import hex_scan_pkg::*;
#(
    parameter int unsigned NDIG      = 4,
    parameter int unsigned DIV       = DEF_DIV,
    parameter int unsigned BLANK_CYC = DEF_BLANK_CYC
) (
    input  logic           clk,
    input  logic           reset,
    hex_scan_ctrl_if.slave bus
);
    localparam int unsigned   IW       = $clog2(NDIG);
    localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

    logic slot_start;
    logic show;

    scan_tick_gen #(
        .DIV       (DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_tick (
        .clk        (clk),
        .reset      (reset),
        .slot_start (slot_start),
        .show       (show)
    );

    logic [4*NDIG-1:0] active_q,     active_d;
    logic [4*NDIG-1:0] pending_q,    pending_d;
    logic              pend_flag_q,  pend_flag_d;
    logic [IW-1:0]     idx_q,        idx_d;
    scan_state_e       state_q,      state_d;
    logic [3:0]        nibble_q,     nibble_d;
    logic [NDIG-1:0]   dig_en_n_q,   dig_en_n_d;
    logic              load_ack_q,   load_ack_d;
    logic              frame_done_q, frame_done_d;
    logic              boundary;
    logic [NDIG-1:0]   sel_n;

`ifdef HEX_SCAN_LZB_EN
    // keep_q[i]=1 lets digit i light; digit 0 always lights. Reset value
    // (all zero) matches active=0 showing a lone "0".
    logic [NDIG-1:1] keep_q, keep_d, keep_calc;
    logic            nz_acc;

    always_comb begin
        nz_acc    = 1'b0;
        keep_calc = '0;
        for (int unsigned i = NDIG - 1; i >= 1; i--) begin
            nz_acc       = nz_acc | (active_d[4*i +: 4] != 4'h0);
            keep_calc[i] = nz_acc;
        end
        keep_d = boundary ? keep_calc : keep_q;
    end
`endif

    always_comb begin
        boundary = slot_start && (idx_q == LAST_IDX);

        idx_d = idx_q;
        if (slot_start) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end

        // Boundary commits the value pending before this edge; a load on
        // the same edge lands in pending for the next frame.
        active_d    = (boundary && pend_flag_q) ? pending_q : active_q;
        pending_d   = bus.load ? bus.value_in : pending_q;
        pend_flag_d = bus.load | (pend_flag_q & ~boundary);

        nibble_d = slot_start ? active_d[{idx_d, 2'b00} +: 4] : nibble_q;
        state_d  = show ? ST_SHOW : ST_BLANK;

        sel_n = NDIG'(digit_en_n(32'(idx_q)));
`ifdef HEX_SCAN_LZB_EN
        sel_n = sel_n | ~{keep_d, 1'b1};
`endif

        dig_en_n_d = dig_en_n_q;
        if (state_d == ST_BLANK) begin
            dig_en_n_d = '1;
        end else if (state_q == ST_BLANK) begin
            dig_en_n_d = sel_n;
        end

        load_ack_d   = bus.load;
        frame_done_d = boundary;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q     <= '0;
            pending_q    <= '0;
            pend_flag_q  <= 1'b0;
            idx_q        <= '0;
            state_q      <= ST_BLANK;
            nibble_q     <= '0;
            dig_en_n_q   <= '1;
            load_ack_q   <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef HEX_SCAN_LZB_EN
            keep_q       <= '0;
`endif
        end else begin
            active_q     <= active_d;
            pending_q    <= pending_d;
            pend_flag_q  <= pend_flag_d;
            idx_q        <= idx_d;
            state_q      <= state_d;
            nibble_q     <= nibble_d;
            dig_en_n_q   <= dig_en_n_d;
            load_ack_q   <= load_ack_d;
            frame_done_q <= frame_done_d;
`ifdef HEX_SCAN_LZB_EN
            keep_q       <= keep_d;
`endif
        end
    end

    assign bus.nibble     = nibble_q;
    assign bus.dig_en_n   = dig_en_n_q;
    assign bus.load_ack   = load_ack_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Bench for hex_scan_ctrl: directed scenarios plus random loads/resets,
// checked every cycle against a cycle-count based reference model.
module tb_hex_scan_ctrl;
    localparam int unsigned NDIG  = 4;
    localparam int unsigned DIV   = 8;
    localparam int unsigned BLANK = 2;
    localparam int unsigned FRAME = NDIG * DIV;
`ifdef HEX_SCAN_LZB_EN
    localparam bit LZB_ON = 1'b1;
`else
    localparam bit LZB_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hex_scan_ctrl_if #(.NDIG(NDIG)) bus ();

    hex_scan_ctrl #(
        .NDIG      (NDIG),
        .DIV       (DIV),
        .BLANK_CYC (BLANK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned t     = 0;

    logic [15:0] m_active  = '0;
    logic [15:0] m_pending = '0;
    logic        m_flag    = 1'b0;
    logic        m_ack     = 1'b0;
    logic        m_fd      = 1'b0;
    logic [3:0]  m_nib     = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0d: got %h, expected %h", tag, t, got, exp);
        end
    endtask

    // Expected enables from slot position and the committed value.
    function automatic logic [3:0] exp_en(input int unsigned tt, input logic [15:0] act);
        int unsigned id  = (tt / DIV) % NDIG;
        int unsigned msd = 0;
        logic [3:0]  m;
        if ((tt % DIV) < BLANK) return 4'hF;
        for (int i = 0; i < NDIG; i++) begin
            if (act[4*i +: 4] != 4'h0) msd = i;
        end
        if (LZB_ON && id > msd) return 4'hF;
        m = 4'b0001 << id;
        return ~m;
    endfunction

    task automatic apply(input logic ld, input logic [15:0] val, input logic rst);
        logic [15:0] sh;
        reset        = rst;
        bus.load     = ld;
        bus.value_in = val;
        @(posedge clk);
        if (rst) begin
            t = 0; m_active = '0; m_pending = '0; m_flag = 1'b0;
            m_ack = 1'b0; m_fd = 1'b0; m_nib = '0;
        end else begin
            if (((t + 1) % FRAME) == 0 && m_flag) begin
                m_active = m_pending;
                m_flag   = 1'b0;
            end
            if (ld) begin
                m_pending = val;
                m_flag    = 1'b1;
            end
            m_ack = ld;
            t++;
            m_fd = ((t % FRAME) == 0);
            if ((t % DIV) == 0) begin
                sh    = m_active >> (4 * ((t / DIV) % NDIG));
                m_nib = sh[3:0];
            end
        end
        @(negedge clk);
        check("dig_en_n",   32'(bus.dig_en_n),   32'(exp_en(t, m_active)));
        check("nibble",     32'(bus.nibble),     32'(m_nib));
        check("load_ack",   32'(bus.load_ack),   32'(m_ack));
        check("frame_done", 32'(bus.frame_done), 32'(m_fd));
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) apply(1'b0, 16'h0, 1'b0);
    endtask

    task automatic align(input int unsigned phase);
        for (int unsigned i = 0; i < FRAME && (t % FRAME) != phase; i++) idle(1);
    endtask

    initial begin
        reset        = 1'b1;
        bus.load     = 1'b0;
        bus.value_in = '0;

        for (int i = 0; i < 3; i++) apply(1'b0, 16'h0, 1'b1);
        idle(40);

        apply(1'b1, 16'h1234, 1'b0);
        idle(100);

        align(5);
        apply(1'b1, 16'hAAAA, 1'b0);
        idle(6);
        apply(1'b1, 16'h0055, 1'b0);
        idle(80);

        align(FRAME - 1);
        apply(1'b1, 16'hBEEF, 1'b0);
        idle(80);

        align(3);
        apply(1'b1, 16'h9999, 1'b0);
        idle(5);
        apply(1'b0, 16'h0, 1'b1);
        idle(50);

        apply(1'b1, 16'h0050, 1'b0);
        idle(80);
        apply(1'b1, 16'h0000, 1'b0);
        idle(80);

        for (int i = 0; i < 5; i++) apply(1'b1, 16'(($urandom)), 1'b0);
        idle(70);

        for (int i = 0; i < 2500; i++) begin
            logic        rst;
            logic        ld;
            logic [15:0] v;
            rst = ($urandom_range(0, 399) == 0);
            ld  = ($urandom_range(0, 7) == 0);
            v   = 16'($urandom);
            if ($urandom_range(0, 3) == 0) v = v & 16'h00FF;
            apply(ld, v, rst);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hex_scan_ctrl.md
Name: hex_scan_ctrl

Overview:
Time-multiplexed scan controller that shares one 4-bit-to-7-segment hex decoder among NDIG common-anode digits.
- Holds an NDIG-nibble display value.
- Steps through the digits at a prescaled rate, presenting one nibble to the shared decoder and enabling one digit at a time.
- Inserts blanking dead-time between digits to prevent ghosting.
- Accepts new values through a load/ack handshake and commits them only at frame boundaries, so no partial frame is shown.

Parameters:
NDIG, 4, number of digits scanned (≥2)
DIV, 50000, clk cycles per digit slot
BLANK_CYC, 16, clk cycles at the start of each slot with all digits off; require 1 ≤ BLANK_CYC < DIV

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
load  in  1  request to capture value_in
value_in  in  4*NDIG  display value; nibble i drives digit i (digit 0 = LS nibble)
load_ack  out  1  one-cycle pulse, the cycle after a load is captured
nibble  out  4  code for the shared hex decoder (registered)
dig_en_n  out  NDIG  active-low digit enables (registered)
frame_done  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset; every register is cleared at the clk edge where reset=1.
- Reset values:
  - active=0, pending=0, pend_flag=0, idx=0, slot_cnt=0, state=BLANK.
  - Outputs: dig_en_n=all 1s, nibble=0, load_ack=0, frame_done=0.
- Slot timing (2-state FSM BLANK/SHOW):
  - slot_cnt runs 0..DIV-1 and wraps; width $clog2(DIV).
  - slot_cnt < BLANK_CYC: state=BLANK, dig_en_n=all 1s.
  - Otherwise: state=SHOW, dig_en_n[idx]=0, all other bits 1.
  - At slot_cnt wrap: idx advances, wrapping NDIG-1 → 0.
- nibble:
  - Loaded with active[4*idx+:4] on the first BLANK cycle of each slot.
  - Held constant for the whole slot, so it is stable ≥BLANK_CYC cycles before the enable asserts.
- Frame period: NDIG*DIV cycles.
- Frame boundary = the edge where idx wraps NDIG-1 → 0. At that edge:
  - frame_done pulses high for one cycle.
  - If pend_flag=1: active ← pending and pend_flag ← 0.
  - The first digit-0 slot after the boundary already uses the new value.
- Load handshake:
  - load=1 at an edge: pending ← value_in, pend_flag ← 1, load_ack=1 for the following cycle.
  - Load is always accepted; there is no backpressure.
  - load held high captures value_in on every cycle and acks every cycle.
  - Several loads within one frame: last writer wins; only the final value is committed.
- Simultaneous load and frame boundary:
  - The boundary commits the pending value that was registered before the edge.
  - The new load lands in pending with pend_flag=1 and commits at the next boundary.
  - If pend_flag was 0, active is unchanged at this boundary.
- Reset mid-operation (including mid-SHOW or with a pending load):
  - Everything returns to reset state on the next edge.
  - Any pending value is discarded; no load_ack is produced for it.
- No combinational path from any input to any output.

Optional Feature:
Macro HEX_SCAN_LZB_EN (leading-zero blanking).
- Defined:
  - Digits above the most-significant non-zero nibble of active keep dig_en_n=1 during their SHOW phase.
  - Digit 0 is always shown; active=0 displays a single "0".
  - The blank mask is registered from active and updated at the frame boundary, together with active.
  - Slot timing, frame_done and nibble sequencing are unchanged.
- Undefined: every digit shows in every slot, and no mask logic is synthesised.

Decomposition:
- Package hex_scan_pkg holds:
  - the FSM state encoding constants ST_BLANK/ST_SHOW;
  - default DIV/BLANK_CYC constants;
  - a function returning the one-hot active-low enable for an index.
- Sub-module scan_tick_gen (parameters DIV, BLANK_CYC) owns slot_cnt and emits two outputs:
  - slot_start: first cycle of each slot;
  - show: cycle is in the SHOW phase.
- The top level owns idx, the active/pending registers, the handshake and the optional LZB mask.

Test Plan (NDIG=4, DIV=8, BLANK_CYC=2):
1. Reset held 3 cycles → dig_en_n=4'b1111, nibble=0, load_ack=0, frame_done=0; first SHOW after release shows digit 0 at cycle 2 with nibble=0.
2. Load 16'h1234 mid-frame → load_ack high exactly 1 cycle later. After the boundary: dig_en_n/nibble sequence 1110/4, 1101/3, 1011/2, 0111/1, each 6 cycles enabled and 2 cycles all-off. frame_done pulses every 32 cycles.
3. Loads 16'hAAAA then 16'h0055 within one frame → only 0055 is committed; 4'hA never appears on nibble.
4. Load 16'hBEEF on the exact boundary cycle, with no prior pend_flag → the current frame still shows the old value; BEEF appears one frame later.
5. Load 16'h9999, then assert reset before the boundary → reset state; 9999 is never displayed; no frame_done in the reset cycle.
6. With HEX_SCAN_LZB_EN: value 16'h0050 → digits 2 and 3 are never enabled; value 16'h0000 → only digit 0 is enabled, with nibble=0.
